// File: rtl/up_down_counter_n.sv
// Parametrised up/down counter: programmable modulus, parallel load, synchronous clear,
// wrap or saturate at the bounds, combinational terminal count and sticky wrap flag.
module up_down_counter_n #(
   parameter int              WIDTH    = 4,
   parameter logic [WIDTH-1:0] MAX     = {WIDTH{1'b1}},
   parameter int              SATURATE = 0
) (
   input  logic             clk,
   input  logic             rst_n,
   input  logic             clr,
   input  logic             load,
   input  logic [WIDTH-1:0] d,
   input  logic             en,
   input  logic             S,
   output logic [WIDTH-1:0] Q,
   output logic             tc,
   output logic             wrap
);

   // Unsigned clamp keeps the count inside 0..MAX, so Q > MAX is unreachable.
   function automatic logic [WIDTH-1:0] clamp(input logic [WIDTH-1:0] v);
      return (v > MAX) ? MAX : v;
   endfunction

   logic             at_max;
   logic             at_zero;
   logic [WIDTH-1:0] q_next;
   logic             wrap_next;

   assign at_max  = (Q == MAX);
   assign at_zero = (Q == '0);
   assign tc      = en & ((S & at_max) | (~S & at_zero));

   always_comb begin
      q_next    = Q;
      wrap_next = wrap;
      if (clr) begin
         q_next    = '0;
         wrap_next = 1'b0;
      end else if (load) begin
         q_next = clamp(d);
      end else if (en) begin
         if (S) begin
            if (at_max) begin
               q_next    = (SATURATE != 0) ? MAX : '0;
               wrap_next = 1'b1;
            end else begin
               q_next = Q + WIDTH'(1);
            end
         end else begin
            if (at_zero) begin
               q_next    = (SATURATE != 0) ? '0 : MAX;
               wrap_next = 1'b1;
            end else begin
               q_next = Q - WIDTH'(1);
            end
         end
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         Q    <= '0;
         wrap <= 1'b0;
      end else begin
         Q    <= q_next;
         wrap <= wrap_next;
      end
   end

endmodule

// File: tb/tb_up_down_counter_n.sv
// Directed bench for up_down_counter_n: wrap, saturate, load/clear priority,
// async reset and a two-stage decade cascade, checked through an expectation queue.
module tb_up_down_counter_n;

   typedef struct {
      string      tag;
      int         which;
      logic [7:0] q;
      logic       tc;
      logic       wrap;
   } exp_t;

   exp_t sb[$];
   int   checks = 0;
   int   fails  = 0;

   logic clk = 1'b0;
   always #5 clk = ~clk;

   // DUT a: wrap mode, MAX=9
   logic       rst_n_a = 1'b1, clr_a = 1'b0, load_a = 1'b0, en_a = 1'b0, s_a = 1'b0;
   logic [3:0] d_a = 4'd0;
   logic [3:0] q_a;
   logic       tc_a, wrap_a;

   // DUT b: saturate mode, MAX=9
   logic       rst_n_b = 1'b1, clr_b = 1'b0, load_b = 1'b0, en_b = 1'b0, s_b = 1'b0;
   logic [3:0] d_b = 4'd0;
   logic [3:0] q_b;
   logic       tc_b, wrap_b;

   // Cascade: units tc drives tens en
   logic       rst_n_c = 1'b1, en_c = 1'b0;
   logic [3:0] q_u, q_t;
   logic       tc_u, wrap_u, tc_t, wrap_t;
   logic [3:0] d_zero = 4'd0;
   logic       zero = 1'b0;
   logic       one  = 1'b1;

   up_down_counter_n #(.WIDTH(4), .MAX(4'd9), .SATURATE(0)) u_a (
      .clk(clk), .rst_n(rst_n_a), .clr(clr_a), .load(load_a), .d(d_a),
      .en(en_a), .S(s_a), .Q(q_a), .tc(tc_a), .wrap(wrap_a));

   up_down_counter_n #(.WIDTH(4), .MAX(4'd9), .SATURATE(1)) u_b (
      .clk(clk), .rst_n(rst_n_b), .clr(clr_b), .load(load_b), .d(d_b),
      .en(en_b), .S(s_b), .Q(q_b), .tc(tc_b), .wrap(wrap_b));

   up_down_counter_n #(.WIDTH(4), .MAX(4'd9), .SATURATE(0)) u_units (
      .clk(clk), .rst_n(rst_n_c), .clr(zero), .load(zero), .d(d_zero),
      .en(en_c), .S(one), .Q(q_u), .tc(tc_u), .wrap(wrap_u));

   up_down_counter_n #(.WIDTH(4), .MAX(4'd9), .SATURATE(0)) u_tens (
      .clk(clk), .rst_n(rst_n_c), .clr(zero), .load(zero), .d(d_zero),
      .en(tc_u), .S(one), .Q(q_t), .tc(tc_t), .wrap(wrap_t));

   task automatic chk(string tag, logic [31:0] obs, logic [31:0] exp);
      checks++;
      assert (obs === exp)
      else begin
         fails++;
         $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
      end
   endtask

   task automatic compare_front();
      exp_t       e;
      logic [7:0] oq;
      logic       otc, ow;
      e = sb.pop_front();
      case (e.which)
         0:       begin oq = {4'd0, q_a}; otc = tc_a; ow = wrap_a; end
         1:       begin oq = {4'd0, q_b}; otc = tc_b; ow = wrap_b; end
         default: begin oq = {q_t, q_u};  otc = tc_u; ow = wrap_u; end
      endcase
      chk({e.tag, "_q"},    32'(oq),  32'(e.q));
      chk({e.tag, "_tc"},   32'(otc), 32'(e.tc));
      chk({e.tag, "_wrap"}, 32'(ow),  32'(e.wrap));
   endtask

   task automatic step(int which, logic c, logic l, logic [3:0] dv, logic e, logic s,
                       logic [7:0] eq, logic etc, logic ew, string tag);
      exp_t x;
      @(negedge clk);
      if (which == 0) begin
         clr_a = c; load_a = l; d_a = dv; en_a = e; s_a = s;
      end else if (which == 1) begin
         clr_b = c; load_b = l; d_b = dv; en_b = e; s_b = s;
      end else begin
         en_c = e;
      end
      x.tag = tag; x.which = which; x.q = eq; x.tc = etc; x.wrap = ew;
      sb.push_back(x);
      @(posedge clk);
      #1;
      compare_front();
   endtask

   initial begin
      // Asynchronous reset with no clock edge involved
      #2;
      rst_n_a = 1'b0; rst_n_b = 1'b0; rst_n_c = 1'b0;
      #1;
      chk("rst_q",    32'(q_a),    32'd0);
      chk("rst_wrap", 32'(wrap_a), 32'd0);
      chk("rst_tc",   32'(tc_a),   32'd0);
      en_a = 1'b1; s_a = 1'b0;
      #1;
      chk("rst_tc_down", 32'(tc_a), 32'd1);
      s_a = 1'b1;
      @(posedge clk);
      #1;
      chk("rst_hold_q", 32'(q_a), 32'd0);
      @(negedge clk);
      rst_n_a = 1'b1; rst_n_b = 1'b1; rst_n_c = 1'b1;
      en_a = 1'b0;

      // Up count through the 9->0 wrap
      for (int k = 1; k <= 12; k++)
         step(0, 0, 0, 4'd0, 1, 1, 8'(k % 10), (k % 10) == 9, k >= 10, "up");

      // Down count through the 0->9 wrap
      step(0, 0, 0, 4'd0, 1, 0, 8'd1, 0, 1, "dn1");
      step(0, 0, 0, 4'd0, 1, 0, 8'd0, 1, 1, "dn0");
      step(0, 0, 0, 4'd0, 1, 0, 8'd9, 0, 1, "dn9");
      step(0, 0, 0, 4'd0, 1, 0, 8'd8, 0, 1, "dn8");

      // Load clamp and priorities
      step(0, 0, 1, 4'd15, 0, 0, 8'd9, 0, 1, "clamp");
      step(0, 1, 1, 4'd5,  0, 0, 8'd0, 0, 0, "clr_over_load");
      step(0, 0, 1, 4'd9,  0, 0, 8'd9, 0, 0, "load9");
      step(0, 0, 1, 4'd3,  1, 1, 8'd3, 0, 0, "load_over_en");
      step(0, 0, 1, 4'd9,  0, 0, 8'd9, 0, 0, "load9b");
      step(0, 1, 0, 4'd0,  1, 1, 8'd0, 0, 0, "clr_on_bound");
      step(0, 0, 0, 4'd0,  1, 0, 8'd9, 0, 1, "dn_wrap");
      step(0, 0, 0, 4'd0,  0, 0, 8'd9, 0, 1, "hold");
      step(0, 0, 1, 4'd5,  0, 0, 8'd5, 0, 1, "load5");
      step(0, 0, 0, 4'd0,  1, 1, 8'd6, 0, 1, "up6");

      // Reset mid-count, between edges
      #2;
      rst_n_a = 1'b0;
      #1;
      chk("arst_q",    32'(q_a),    32'd0);
      chk("arst_wrap", 32'(wrap_a), 32'd0);
      @(posedge clk);
      #1;
      chk("arst_hold_q", 32'(q_a), 32'd0);
      @(negedge clk);
      rst_n_a = 1'b1;
      @(posedge clk);
      #1;
      chk("arst_first_q", 32'(q_a), 32'd1);

      // Saturate mode
      step(1, 0, 1, 4'd8, 0, 0, 8'd8, 0, 0, "sat_load8");
      step(1, 0, 0, 4'd0, 1, 1, 8'd9, 1, 0, "sat_up9");
      step(1, 0, 0, 4'd0, 1, 1, 8'd9, 1, 1, "sat_hold9a");
      step(1, 0, 0, 4'd0, 1, 1, 8'd9, 1, 1, "sat_hold9b");
      step(1, 1, 0, 4'd0, 0, 0, 8'd0, 0, 0, "sat_clr");
      step(1, 0, 0, 4'd0, 1, 0, 8'd0, 1, 1, "sat_hold0a");
      step(1, 0, 0, 4'd0, 1, 0, 8'd0, 1, 1, "sat_hold0b");

      // Decade cascade: expected value packed as {tens, units}
      for (int k = 1; k <= 25; k++)
         step(2, 0, 0, 4'd0, 1, 1, 8'(((k / 10) * 16) + (k % 10)), (k % 10) == 9, k >= 10,
              "cascade");

      chk("sb_empty", 32'(sb.size()), 32'd0);
      $display("%0d/%0d checks passed", checks - fails, checks);
      $finish;
   end

endmodule

// File: doc/up_down_counter_n.md
# up_down_counter_n

Parametrised synchronous up/down counter with programmable modulus, parallel load, synchronous clear, wrap or saturate mode, terminal-count output and sticky wrap flag. It generalises the fixed 4-bit up/down counter of this lab series to arbitrary width and modulus. It serves as the counting core for decade counters, cascaded timers and the upcoming stopwatch/display labs. Cascading uses `tc` of one stage driving `en` of the next.

## Interface
- `WIDTH`, default 4: counter width in bits, 1..32.
- `MAX`, default 2**WIDTH-1: highest count value, 1..2**WIDTH-1. The count range is 0..MAX.
- `SATURATE`, default 0: 0 = wrap at the bounds, 1 = hold at the bounds.

Ports:
- `clk`  in  1  clock; all state updates on the rising edge.
- `rst_n`  in  1  asynchronous, active-low reset.
- `clr`  in  1  synchronous clear of count and flag.
- `load`  in  1  synchronous parallel load from `d`.
- `d`  in  WIDTH  load value.
- `en`  in  1  count enable.
- `S`  in  1  direction: 1 = up, 0 = down.
- `Q`  out  WIDTH  current count (registered).
- `tc`  out  1  terminal count (combinational).
- `wrap`  out  1  sticky flag (registered): a wrap or saturation event has occurred since the last clear.

## Operation
- Per-edge priority: `clr` > `load` > `en` > hold.
- `clr`=1: `Q`<=0 and `wrap`<=0.
- `load`=1: `Q`<=min(`d`, MAX). The clamp is unsigned. `wrap` is unchanged.
- `en`=1, `S`=1:
  - `Q`<MAX: `Q`<=`Q`+1.
  - `Q`==MAX: `Q`<=0 if SATURATE=0; otherwise `Q` holds at MAX. In both cases `wrap`<=1.
- `en`=1, `S`=0:
  - `Q`>0: `Q`<=`Q`-1.
  - `Q`==0: `Q`<=MAX if SATURATE=0; otherwise `Q` holds at 0. In both cases `wrap`<=1.
- `en`=0 with no `clr`/`load`: `Q` and `wrap` hold.
- `tc` = `en` & ((`S` & `Q`==MAX) | (~`S` & `Q`==0)). It is asserted in the cycle before a bound event, so the next stage counts on the same edge.
- Out-of-range state (`Q`>MAX) cannot occur, because load clamps. Counting arithmetic is modulo MAX+1, not modulo 2**WIDTH.
- `S` may change on any cycle. The direction in effect is the value sampled at the edge.

## Timing
- Reset: `rst_n` low forces `Q`=0 and `wrap`=0 immediately, regardless of `clk`. `tc` follows combinationally (1 if `en`=1 and `S`=0).
- Release of `rst_n` is synchronous to the design. The first count occurs on the first rising edge with `rst_n` high and `en`=1.
- Reset asserted mid-count aborts the count with no partial update. A `load` or `clr` on the same edge as reset deassertion is ignored only if `rst_n` is still low at that edge.
- Latency: `Q` updates one edge after `clr`/`load`/`en` is sampled. `tc` has zero latency from `Q`, `en` and `S`. `wrap` sets on the same edge as the bound event.
- Simultaneous events:
  - `clr` & `load`: clear wins.
  - `load` & `en` at a bound: load wins and `wrap` is not set.
  - `clr` on a bound-event edge: `wrap` ends at 0.
- No multicycle paths. `tc` is the only combinational output.

## Test plan
- Reset/up-wrap (WIDTH=4, MAX=9, SATURATE=0): pulse `rst_n` low, then `en`=1, `S`=1 for 12 edges.
  - Required: `Q` = 1..9,0,1,2.
  - `tc`=1 only while `Q`=9.
  - `wrap` rises on the 9→0 edge and stays high.
- Down-wrap: from `Q`=2 with `S`=0, `en`=1 for 4 edges.
  - Required: `Q` = 1,0,9,8.
  - `tc`=1 while `Q`=0.
- Saturate (MAX=9, SATURATE=1): load 8, then count up 3 edges.
  - Required: `Q` = 9,9,9 and `wrap`=1.
  - Then `S`=0 from `Q`=0 for 2 edges: `Q` stays 0.
- Load/clamp/priority: `d`=15, `load`=1 with MAX=9.
  - Required: `Q`=9.
  - `d`=5 with `clr`=`load`=1: `Q`=0 and `wrap`=0.
  - `d`=3 with `load`=`en`=1, `S`=1, from `Q`=9: `Q`=3 and `wrap` unchanged.
- Async reset mid-count: at `Q`=6 drive `rst_n` low between edges.
  - Required: `Q`=0 and `wrap`=0 before the next edge, held while `rst_n` is low.
  - After release: `Q`=1 on the first edge with `en`=1, `S`=1.
- Cascade: two instances (MAX=9), the units `tc` driving the tens `en`, 25 edges up from 0.
  - Required: tens=2 and units=5.
  - Tens increments exactly on the units 9→0 edges.
